// File: rtl/b16_boot_mem.sv
// b16_boot_mem: banked boot memory with a pipelined strobe/ready read path, a lockable loader
// write port and out-of-range detection. Define B16MEM_PARITY_EN for per-byte parity and par_err_o.
module b16_boot_mem #(
  parameter int    DATA_W     = 16,
  parameter int    BANK_WORDS = 1024,
  parameter int    BANKS      = 2,
  parameter int    READ_LAT   = 1,
  parameter string INIT_FILE  = "none"
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  strobe_i,
  input  logic [31:0]           addr_i,
  input  logic                  wr_en_i,
  input  logic [DATA_W/8-1:0]   byte_en_i,
  input  logic [DATA_W-1:0]     wr_data_i,
  input  logic                  lock_i,
  output logic [DATA_W-1:0]     rd_data_o,
  output logic                  ready_o,
  output logic                  range_err_o,
  output logic                  wr_err_o,
`ifdef B16MEM_PARITY_EN
  output logic                  par_err_o,
`endif
  output logic                  locked_o
);

  localparam int NB    = DATA_W / 8;
  localparam int B     = $clog2(NB);
  localparam int W     = $clog2(BANK_WORDS);
  localparam int BW    = (BANKS > 1) ? $clog2(BANKS) : 1;
  localparam int DEPTH = BANKS * BANK_WORDS;
  localparam int IW    = $clog2(DEPTH);
`ifdef B16MEM_PARITY_EN
  localparam int LANE_W = 9;
`else
  localparam int LANE_W = 8;
`endif
  localparam logic [BW:0] BANKS_L = BANKS[BW:0];

  if ((DATA_W != 16 && DATA_W != 32) || BANKS < 1 || BANKS > 8 ||
      (READ_LAT != 1 && READ_LAT != 2) || BANK_WORDS < 16 ||
      (BANK_WORDS & (BANK_WORDS - 1)) != 0) begin : g_param_err
    $error("b16_boot_mem: unsupported parameter combination");
  end

  logic [NB-1:0][LANE_W-1:0] mem_q [DEPTH];

  initial begin
    for (int i = 0; i < DEPTH; i++) mem_q[i] = '0;
  end

  logic [W-1:0]      word_idx;
  logic [BW-1:0]     bank_idx;
  logic [BW+W-1:0]   flat_idx;
  logic [IW-1:0]     mem_idx;
  logic              in_range;
  logic              rd_req;
  logic              wr_req;
  logic              wr_ok;
  logic              unused_bits;

  // bank < BANKS guarantees {bank, word} == bank*BANK_WORDS + word fits in DEPTH.
  assign word_idx    = addr_i[B +: W];
  assign bank_idx    = addr_i[B+W +: BW];
  assign flat_idx    = {bank_idx, word_idx};
  assign mem_idx     = flat_idx[IW-1:0];
  assign in_range    = ({1'b0, bank_idx} < BANKS_L);
  assign rd_req      = strobe_i & ~wr_en_i;
  assign wr_req      = strobe_i & wr_en_i;
  assign unused_bits = ^{addr_i, flat_idx};

  logic locked_q, locked_d;
  logic wr_err_q, wr_err_d;

  // The lock is sampled before it updates, so a write in the lock cycle still lands.
  assign wr_ok    = wr_req & ~locked_q & in_range;
  assign wr_err_d = wr_req & (locked_q | ~in_range);
  assign locked_d = locked_q | lock_i;

`ifdef B16MEM_PARITY_EN
  function automatic logic [NB-1:0] lane_par(input logic [DATA_W-1:0] d);
    logic [NB-1:0] p;
    for (int l = 0; l < NB; l++) p[l] = ^d[8*l +: 8];
    return p;
  endfunction
`endif

  logic [NB-1:0][LANE_W-1:0] wr_word;

  always_comb begin
    wr_word = '0;
    for (int l = 0; l < NB; l++) begin
      wr_word[l][7:0] = wr_data_i[8*l +: 8];
`ifdef B16MEM_PARITY_EN
      wr_word[l][8] = ^wr_data_i[8*l +: 8];
`endif
    end
  end

  // Memory has no reset: contents survive rst_i.
  always @(posedge clk_i) begin
    if (wr_ok) begin
      for (int l = 0; l < NB; l++) begin
        if (byte_en_i[l]) mem_q[mem_idx][l] <= wr_word[l];
      end
    end
  end

  logic                      s1_valid_q, s1_valid_d;
  logic                      s1_oor_q, s1_oor_d;
  logic [DATA_W-1:0]         s1_data_q, s1_data_d;
  logic [NB-1:0][LANE_W-1:0] rd_word;
`ifdef B16MEM_PARITY_EN
  logic [NB-1:0]             s1_par_q, s1_par_d;
  logic                      par_err_q, par_err_d;
`endif

  always_comb begin
    rd_word    = mem_q[mem_idx];
    s1_valid_d = rd_req;
    s1_oor_d   = rd_req & ~in_range;
    s1_data_d  = '0;
`ifdef B16MEM_PARITY_EN
    s1_par_d   = '0;
`endif
    if (rd_req && in_range) begin
      for (int l = 0; l < NB; l++) begin
        s1_data_d[8*l +: 8] = rd_word[l][7:0];
`ifdef B16MEM_PARITY_EN
        s1_par_d[l] = rd_word[l][8];
`endif
      end
    end
  end

`ifdef B16MEM_PARITY_EN
  assign par_err_d = par_err_q |
                     (s1_valid_q & ~s1_oor_q & (|(s1_par_q ^ lane_par(s1_data_q))));
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      locked_q   <= 1'b0;
      wr_err_q   <= 1'b0;
      s1_valid_q <= 1'b0;
      s1_oor_q   <= 1'b0;
      s1_data_q  <= '0;
`ifdef B16MEM_PARITY_EN
      s1_par_q   <= '0;
      par_err_q  <= 1'b0;
`endif
    end else begin
      locked_q   <= locked_d;
      wr_err_q   <= wr_err_d;
      s1_valid_q <= s1_valid_d;
      s1_oor_q   <= s1_oor_d;
      s1_data_q  <= s1_data_d;
`ifdef B16MEM_PARITY_EN
      s1_par_q   <= s1_par_d;
      par_err_q  <= par_err_d;
`endif
    end
  end

  logic              out_valid;
  logic              out_oor;
  logic [DATA_W-1:0] out_data;

  if (READ_LAT == 2) begin : g_lat2
    logic              s2_valid_q;
    logic              s2_oor_q;
    logic [DATA_W-1:0] s2_data_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        s2_valid_q <= 1'b0;
        s2_oor_q   <= 1'b0;
        s2_data_q  <= '0;
      end else begin
        s2_valid_q <= s1_valid_q;
        s2_oor_q   <= s1_oor_q;
        s2_data_q  <= s1_data_q;
      end
    end

    assign out_valid = s2_valid_q;
    assign out_oor   = s2_oor_q;
    assign out_data  = s2_data_q;
  end else begin : g_lat1
    assign out_valid = s1_valid_q;
    assign out_oor   = s1_oor_q;
    assign out_data  = s1_data_q;
  end

  assign rd_data_o   = out_data;
  assign ready_o     = out_valid;
  assign range_err_o = out_oor;
  assign wr_err_o    = wr_err_q;
  assign locked_o    = locked_q;
`ifdef B16MEM_PARITY_EN
  assign par_err_o   = par_err_q;
`endif

endmodule

// File: tb/tb_b16_boot_mem.sv
// Directed bench: default instance (16b, 2 banks, latency 1) and a wide instance
// (32b, 3 banks, latency 2) exercising decode, lock, range errors and reset flush.
module tb_b16_boot_mem;

  logic clk;
  logic rst_a, rst_b;

  logic        a_stb, a_we, a_lock;
  logic [31:0] a_addr;
  logic [1:0]  a_be;
  logic [15:0] a_wd, a_rd;
  logic        a_rdy, a_rerr, a_werr, a_lkd;

  logic        b_stb, b_we, b_lock;
  logic [31:0] b_addr;
  logic [3:0]  b_be;
  logic [31:0] b_wd, b_rd;
  logic        b_rdy, b_rerr, b_werr, b_lkd;

  int total = 0;
  int bad   = 0;

  b16_boot_mem dut_a (
    .clk_i(clk), .rst_i(rst_a), .strobe_i(a_stb), .addr_i(a_addr), .wr_en_i(a_we),
    .byte_en_i(a_be), .wr_data_i(a_wd), .lock_i(a_lock), .rd_data_o(a_rd),
    .ready_o(a_rdy), .range_err_o(a_rerr), .wr_err_o(a_werr), .locked_o(a_lkd)
  );

  b16_boot_mem #(.DATA_W(32), .BANK_WORDS(1024), .BANKS(3), .READ_LAT(2)) dut_b (
    .clk_i(clk), .rst_i(rst_b), .strobe_i(b_stb), .addr_i(b_addr), .wr_en_i(b_we),
    .byte_en_i(b_be), .wr_data_i(b_wd), .lock_i(b_lock), .rd_data_o(b_rd),
    .ready_o(b_rdy), .range_err_o(b_rerr), .wr_err_o(b_werr), .locked_o(b_lkd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_a = 1'b1; rst_b = 1'b1;
    a_stb = 0; a_we = 0; a_lock = 0; a_addr = 0; a_be = 0; a_wd = 0;
    b_stb = 0; b_we = 0; b_lock = 0; b_addr = 0; b_be = 0; b_wd = 0;
    cyc(); cyc();
    chk("a_reset_rdy",  32'(a_rdy),  32'h0);
    chk("a_reset_rd",   32'(a_rd),   32'h0);
    chk("a_reset_rerr", 32'(a_rerr), 32'h0);
    chk("a_reset_werr", 32'(a_werr), 32'h0);
    chk("a_reset_lkd",  32'(a_lkd),  32'h0);
    chk("b_reset_rdy",  32'(b_rdy),  32'h0);
    chk("b_reset_lkd",  32'(b_lkd),  32'h0);
    rst_a = 1'b0; rst_b = 1'b0;
    cyc();

    // ---- instance A: load bank0 word0 and bank1 word1
    a_stb = 1; a_we = 1; a_be = 2'b11; a_addr = 32'h000; a_wd = 16'h1234;
    cyc();
    chk("a_write_no_ready", 32'(a_rdy), 32'h0);
    a_addr = 32'h802; a_wd = 16'hBEEF;
    cyc();
    chk("a_write_no_werr", 32'(a_werr), 32'h0);
    a_we = 0; a_addr = 32'h000;
    cyc();
    chk("a_rd0_rdy",  32'(a_rdy),  32'h1);
    chk("a_rd0_data", 32'(a_rd),   32'h1234);
    chk("a_rd0_rerr", 32'(a_rerr), 32'h0);
    a_addr = 32'h802;
    cyc();
    chk("a_rd1_rdy",  32'(a_rdy),  32'h1);
    chk("a_rd1_data", 32'(a_rd),   32'hBEEF);
    a_stb = 0;
    cyc();
    chk("a_idle_rdy", 32'(a_rdy), 32'h0);
    chk("a_idle_rd",  32'(a_rd),  32'h0);

    // byte-lane write, then read-after-write next cycle
    a_stb = 1; a_we = 1; a_addr = 32'h010; a_be = 2'b11; a_wd = 16'h1111;
    cyc();
    a_be = 2'b10; a_wd = 16'hA55A;
    cyc();
    a_we = 0;
    cyc();
    chk("a_raw_lane", 32'(a_rd), 32'hA511);
    a_addr = 32'h1010;
    cyc();
    chk("a_alias_hi", 32'(a_rd), 32'hA511);
    a_we = 1; a_addr = 32'h011; a_be = 2'b00; a_wd = 16'hFFFF;
    cyc();
    chk("a_be0_werr", 32'(a_werr), 32'h0);
    a_we = 0; a_addr = 32'h011;
    cyc();
    chk("a_be0_noop", 32'(a_rd), 32'hA511);

    // lock, then rejected write
    a_stb = 0; a_lock = 1;
    cyc();
    a_lock = 0;
    chk("a_locked", 32'(a_lkd), 32'h1);
    a_stb = 1; a_we = 1; a_addr = 32'h010; a_be = 2'b11; a_wd = 16'hFFFF;
    cyc();
    chk("a_lock_werr", 32'(a_werr), 32'h1);
    a_stb = 0; a_we = 0;
    cyc();
    chk("a_werr_pulse", 32'(a_werr), 32'h0);
    chk("a_still_locked", 32'(a_lkd), 32'h1);
    a_stb = 1; a_addr = 32'h010;
    cyc();
    chk("a_lock_protect", 32'(a_rd), 32'hA511);
    a_stb = 0;
    rst_a = 1'b1;
    cyc();
    chk("a_rst_unlock", 32'(a_lkd), 32'h0);
    rst_a = 1'b0;
    cyc();

    // lock and write in the same cycle: write lands
    a_stb = 1; a_we = 1; a_lock = 1; a_addr = 32'h020; a_be = 2'b11; a_wd = 16'h5A5A;
    cyc();
    a_lock = 0;
    chk("a_lockwr_werr", 32'(a_werr), 32'h0);
    chk("a_lockwr_lkd",  32'(a_lkd),  32'h1);
    a_we = 0;
    cyc();
    chk("a_lockwr_data", 32'(a_rd), 32'h5A5A);
    a_addr = 32'h000;
    cyc();
    chk("a_retained", 32'(a_rd), 32'h1234);
    a_stb = 0;
    cyc();

    // ---- instance B: load 8 words, then 8 back-to-back reads
    b_stb = 1; b_we = 1; b_be = 4'hF;
    for (int i = 0; i < 8; i++) begin
      b_addr = 32'(4 * i);
      b_wd   = 32'hC0DE_0000 | 32'(i);
      cyc();
    end
    b_we = 0;
    for (int k = 0; k < 10; k++) begin
      b_stb  = (k < 8);
      b_addr = 32'(4 * k);
      cyc();
      if (k >= 1 && k <= 8) begin
        chk("b_burst_rdy",  32'(b_rdy), 32'h1);
        chk("b_burst_data", b_rd, 32'hC0DE_0000 | 32'(k - 1));
      end else begin
        chk("b_burst_idle", 32'(b_rdy), 32'h0);
      end
    end

    // out-of-range read (bank 3 of 3)
    b_stb = 1; b_we = 0; b_addr = 32'h3004;
    cyc();
    b_stb = 0;
    chk("b_oor_lat1", 32'(b_rdy), 32'h0);
    cyc();
    chk("b_oor_rdy",  32'(b_rdy),  32'h1);
    chk("b_oor_rerr", 32'(b_rerr), 32'h1);
    chk("b_oor_data", b_rd,        32'h0);
    cyc();
    chk("b_oor_clear", 32'(b_rerr), 32'h0);
    b_stb = 1; b_we = 1; b_addr = 32'h3004; b_wd = 32'h1;
    cyc();
    chk("b_oor_werr", 32'(b_werr), 32'h1);

    // partial lanes into bank 2
    b_addr = 32'h2008; b_be = 4'b0101; b_wd = 32'hDEAD_BEEF;
    cyc();
    chk("b_bank2_werr", 32'(b_werr), 32'h0);
    b_we = 0;
    cyc();
    b_stb = 0;
    cyc();
    chk("b_bank2_data", b_rd, 32'h00AD_00EF);

    // reset with two reads in flight
    b_stb = 1; b_addr = 32'h000;
    cyc();
    b_addr = 32'h004;
    #2;
    rst_b = 1'b1; b_stb = 0;
    #1;
    chk("b_rst_rdy_now", 32'(b_rdy), 32'h0);
    cyc();
    rst_b = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("b_flush_rdy",  32'(b_rdy),  32'h0);
      chk("b_flush_rd",   b_rd,        32'h0);
      chk("b_flush_rerr", 32'(b_rerr), 32'h0);
    end
    b_stb = 1; b_addr = 32'h004;
    cyc();
    b_stb = 0;
    cyc();
    chk("b_post_rst_rdy",  32'(b_rdy), 32'h1);
    chk("b_post_rst_data", b_rd,       32'hC0DE_0001);
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
